// File: rtl/md_sequencer.sv
// Multi-cycle mult/div sequencer holding architectural HI/LO; results land exactly MULT_CYC/DIV_CYC clocks after issue.
// No backpressure on issue: while busy, new start/mthi/mtlo are dropped and stall_md holds a D-stage md-class instruction.
module md_sequencer #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        IntReq,
  input  logic        mul_div_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   a_q, b_q;
  logic [1:0]    op_q;

  logic [63:0] prod;
  logic [63:0] res;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  // Sign-extending before a 64-bit multiply gives the signed product modulo 2^64.
  always_comb begin
    a_neg    = ~op_q[0] & a_q[31];
    b_neg    = ~op_q[0] & b_q[31];
    prod     = {{32{a_neg}}, a_q} * {{32{b_neg}}, b_q};
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    div_zero = (b_q == 32'd0);
    q_mag    = div_zero ? 32'd0 : a_mag / b_mag;
    r_mag    = div_zero ? 32'd0 : a_mag % b_mag;
    quo      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem      = a_neg ? -r_mag : r_mag;
    res      = op_q[1] ? {rem, quo} : prod;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !IntReq) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= op;
            cnt   <= op[1] ? CW'(DIV_CYC) : CW'(MULT_CYC);
            state <= RUN;
          end else if (!start && !IntReq) begin
            if (hi_we) HI <= wdata;
            if (lo_we) LO <= wdata;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= IDLE;
            // A zero divisor still spends the full latency but leaves HI/LO alone.
            if (!(op_q[1] && div_zero)) begin
              HI <= res[63:32];
              LO <= res[31:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == RUN) | start;
  assign stall_md = mul_div_d & busy;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed corner cases then random traffic against an arithmetic reference model.
module tb_md_sequencer;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we, IntReq, mul_div_d;
  logic [1:0]  op;
  logic [31:0] A, B, wdata;
  logic        busy, stall_md;
  logic [31:0] HI, LO;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        p_wr;
  int          cyc, done_at;

  md_sequencer #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .IntReq(IntReq),
    .mul_div_d(mul_div_d), .busy(busy), .stall_md(stall_md), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {HI,LO}; wr=0 when the operation must not touch HI/LO.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b, output logic wr);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    wr = 1'b1;
    t  = '0;
    case (o)
      2'b00: t = sa * sb;
      2'b01: t = ua * ub;
      2'b10: begin
        if (b == 32'd0) wr = 1'b0;
        else begin
          q = sa / sb;
          r = sa % sb;
          t = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) wr = 1'b0;
        else begin
          uq = ua / ub;
          ur = ua % ub;
          t = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return t;
  endfunction

  task automatic drive(input logic s, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic hw, input logic lw, input logic [31:0] wd, input logic irq, input logic md);
    logic exp_busy;
    start = s; op = o; A = a; B = b; hi_we = hw; lo_we = lw; wdata = wd; IntReq = irq; mul_div_d = md;
    #1;
    exp_busy = (cyc < done_at) || s;
    check("busy", {31'd0, busy}, {31'd0, exp_busy});
    check("stall_md", {31'd0, stall_md}, {31'd0, md & exp_busy});
  endtask

  task automatic edge_step();
    logic        in_run;
    logic [63:0] r;
    in_run = (cyc < done_at);
    @(posedge clk);
    if (in_run) begin
      if (cyc + 1 == done_at && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start && !IntReq) begin
      r       = ref_result(op, A, B, p_wr);
      p_hi    = r[63:32];
      p_lo    = r[31:0];
      done_at = cyc + 1 + (op[1] ? DC : MC);
    end else if (!IntReq) begin
      if (hi_we) m_hi = wdata;
      if (lo_we) m_lo = wdata;
    end
    cyc++;
    #1;
    check("HI", HI, m_hi);
    check("LO", LO, m_lo);
  endtask

  task automatic idle(input int n, input logic md);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, md);
      edge_step();
    end
  endtask

  initial begin
    logic        s, hw, lw, irq, md;
    logic [1:0]  o;
    logic [31:0] a, b, wd;

    reset = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; IntReq = 1'b0; mul_div_d = 1'b0;
    m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_wr = 1'b0; cyc = 0; done_at = 0;

    #3;
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; mul_div_d = 1'b1;
    #1;
    check("rst_busy_start", {31'd0, busy}, 32'd1);
    check("rst_stall_start", {31'd0, stall_md}, 32'd1);
    start = 1'b0; mul_div_d = 1'b0;
    #8 reset = 1'b1;
    @(posedge clk); #1;

    // signed mult with D-stage stall held high
    drive(1'b1, 2'b00, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    edge_step();
    idle(4, 1'b1);
    check("mult_hold_lo", LO, 32'd0);
    idle(1, 1'b1);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFFA);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check("stall_after", {31'd0, stall_md}, 32'd0);
    edge_step();

    drive(1'b1, 2'b01, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    edge_step();
    idle(5, 1'b0);
    check("multu_hi", HI, 32'h00000002);
    check("multu_lo", LO, 32'hFFFFFFFA);

    // mthi/mtlo in IDLE, then ignored during RUN
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);
    edge_step();
    check("mt_hi", HI, 32'h12345678);
    check("mt_lo", LO, 32'h12345678);
    drive(1'b1, 2'b00, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    edge_step();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    edge_step();
    check("mt_run_ignored", HI, 32'h12345678);
    idle(4, 1'b0);
    check("mult12_hi", HI, 32'd0);
    check("mult12_lo", LO, 32'd12);

    // signed div with an interrupt pulse in cycle 2
    drive(1'b1, 2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    edge_step();
    idle(1, 1'b0);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    edge_step();
    idle(7, 1'b0);
    check("div_edge9_lo", LO, 32'd12);
    idle(1, 1'b0);
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);

    // divu by zero keeps HI/LO
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'd5, 1'b0, 1'b0);
    edge_step();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'd6, 1'b0, 1'b0);
    edge_step();
    drive(1'b1, 2'b11, 32'd7, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    edge_step();
    idle(9, 1'b0);
    check("div0_busy", {31'd0, busy}, 32'd1);
    idle(1, 1'b0);
    check("div0_busy_done", {31'd0, busy}, 32'd0);
    check("div0_hi", HI, 32'd5);
    check("div0_lo", LO, 32'd6);

    drive(1'b1, 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    edge_step();
    idle(10, 1'b0);
    check("ovf_lo", LO, 32'h80000000);
    check("ovf_hi", HI, 32'd0);

    // start blocked by IntReq; start beats mthi/mtlo; mthi blocked by IntReq
    drive(1'b1, 2'b00, 32'd5, 32'd5, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    edge_step();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check("irq_start_idle", {31'd0, busy}, 32'd0);
    edge_step();
    check("irq_start_lo", LO, 32'h80000000);
    drive(1'b1, 2'b01, 32'd2, 32'd3, 1'b1, 1'b1, 32'hFFFF0000, 1'b0, 1'b0);
    edge_step();
    idle(5, 1'b0);
    check("prio_hi", HI, 32'd0);
    check("prio_lo", LO, 32'd6);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0000ABCD, 1'b1, 1'b0);
    edge_step();
    check("irq_mt_lo", LO, 32'd6);

    // asynchronous reset in cycle 3 of a mult
    drive(1'b1, 2'b00, 32'd7, 32'd9, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    edge_step();
    idle(2, 1'b0);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("amid_rst_hi", HI, 32'd0);
    check("amid_rst_lo", LO, 32'd0);
    check("amid_rst_busy", {31'd0, busy}, 32'd0);
    start = 1'b1;
    #1;
    check("amid_rst_busy_start", {31'd0, busy}, 32'd1);
    start = 1'b0;
    #1 reset = 1'b1;
    m_hi = '0; m_lo = '0; done_at = cyc;
    idle(12, 1'b0);
    check("post_rst_lo", LO, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      s   = ($urandom_range(0, 3) == 0);
      o   = 2'($urandom_range(0, 3));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      hw  = ($urandom_range(0, 3) == 0);
      lw  = ($urandom_range(0, 3) == 0);
      wd  = $urandom;
      irq = ($urandom_range(0, 7) == 0);
      md  = 1'($urandom_range(0, 1));
      drive(s, o, a, b, hw, lw, wd, irq, md);
      edge_step();
    end
    idle(12, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
